// File: rtl/wb_write_buffer_pkg.sv
// Shared constants for the writeback path.
//   WORD_WIDTH     : register-file data width
//   REG_FILE_DEPTH : register index width (address bits)
//   REG_FILE_SIZE  : number of architectural registers
package wb_write_buffer_pkg;

   localparam int unsigned WORD_WIDTH     = 32;
   localparam int unsigned REG_FILE_DEPTH = 4;
   localparam int unsigned REG_FILE_SIZE  = 16;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first forwarding search over the write buffer for one lookup address.
//   wr_ptr  : next write slot; the slot just before it holds the youngest entry
//   valid   : per-slot occupancy
//   dests   : per-slot destination register
//   results : per-slot result value
//   src     : lookup address
//   hit     : some valid slot targets src
//   val     : result of the youngest matching slot, 0 on a miss
module wb_fwd_match #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned REG_ADDR_W = 4,
   localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
   input  logic [PTR_W-1:0]                        wr_ptr,
   input  logic [DEPTH-1:0]                        valid,
   input  logic [DEPTH-1:0][REG_ADDR_W-1:0]        dests,
   input  logic [DEPTH-1:0][WORD_WIDTH-1:0]        results,
   input  logic [REG_ADDR_W-1:0]                   src,
   output logic                                    hit,
   output logic [WORD_WIDTH-1:0]                   val
);

   logic [PTR_W-1:0] idx;

   // Walk from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1); later matches
   // overwrite earlier ones so the youngest entry wins.
   always_comb begin
      hit = 1'b0;
      val = '0;
      idx = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = wr_ptr - PTR_W'(k);
         if (valid[idx] && (dests[idx] == src)) begin
            hit = 1'b1;
            val = results[idx];
         end
      end
   end

endmodule

// File: rtl/wb_write_buffer.sv
// In-order writeback buffer in front of the register-file write port.
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous clear of all buffered entries
//   in_valid/in_ready    : writeback request handshake
//   in_dest, in_result   : request payload
//   rf_ready             : register-file write port granted this cycle
//   wb_en/wb_dest/...    : register-file write (head entry, combinational)
//   src1/src2            : forwarding lookup addresses
//   fwdN_hit/fwdN_val    : youngest buffered value for srcN
//   count, full, empty   : occupancy
module wb_write_buffer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned WORD_WIDTH = wb_write_buffer_pkg::WORD_WIDTH,
   parameter int unsigned REG_ADDR_W = wb_write_buffer_pkg::REG_FILE_DEPTH,
   localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic [WORD_WIDTH-1:0] in_result,
   input  logic                  rf_ready,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_dest,
   output logic [WORD_WIDTH-1:0] wb_result,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   output logic                  fwd1_hit,
   output logic [WORD_WIDTH-1:0] fwd1_val,
   output logic                  fwd2_hit,
   output logic [WORD_WIDTH-1:0] fwd2_val,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   import wb_write_buffer_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic [DEPTH-1:0]                 valid_q, valid_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q;
   logic [DEPTH-1:0][WORD_WIDTH-1:0] result_q;
   logic                             pop;
   logic                             push;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   // Flush suppresses the register-file write so no flushed entry retires.
   assign pop      = !empty && rf_ready && !flush;
   // A full buffer still accepts when the head retires in the same cycle.
   assign in_ready = !full || pop;
   assign push     = in_valid && in_ready && !flush;

   assign wb_en     = pop;
   assign wb_dest   = dest_q[rd_ptr_q];
   assign wb_result = result_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         valid_d  = '0;
      end else begin
         if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
         end
         // Applied after the pop so a full buffer retiring and refilling the
         // same slot keeps it valid.
         if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // Payload storage is not reset; occupancy is tracked by valid_q/count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_ptr_q]   <= in_dest;
         result_q[wr_ptr_q] <= in_result;
      end
   end

   wb_fwd_match #(
      .DEPTH      (DEPTH),
      .WORD_WIDTH (WORD_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd1 (
      .wr_ptr  (wr_ptr_q),
      .valid   (valid_q),
      .dests   (dest_q),
      .results (result_q),
      .src     (src1),
      .hit     (fwd1_hit),
      .val     (fwd1_val)
   );

   wb_fwd_match #(
      .DEPTH      (DEPTH),
      .WORD_WIDTH (WORD_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd2 (
      .wr_ptr  (wr_ptr_q),
      .valid   (valid_q),
      .dests   (dest_q),
      .results (result_q),
      .src     (src2),
      .hit     (fwd2_hit),
      .val     (fwd2_val)
   );

endmodule

// File: tb/tb_wb_write_buffer.sv
module tb_wb_write_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_dest;
   logic [31:0] in_result;
   logic        rf_ready;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_result;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        fwd1_hit;
   logic [31:0] fwd1_val;
   logic        fwd2_hit;
   logic [31:0] fwd2_val;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_write_buffer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dest   (in_dest),
      .in_result (in_result),
      .rf_ready  (rf_ready),
      .wb_en     (wb_en),
      .wb_dest   (wb_dest),
      .wb_result (wb_result),
      .src1      (src1),
      .src2      (src2),
      .fwd1_hit  (fwd1_hit),
      .fwd1_val  (fwd1_val),
      .fwd2_hit  (fwd2_hit),
      .fwd2_val  (fwd2_val),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   typedef struct {
      logic        v;
      logic [3:0]  d;
      logic [31:0] r;
      logic        rr;
      logic        fl;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        e_en;
      logic [3:0]  e_dest;
      logic [31:0] e_res;
      logic        e_rdy;
      int          e_cnt;
      logic        e_h1;
      logic [31:0] e_v1;
      logic        e_h2;
      logic [31:0] e_v2;
   } vec_t;

   typedef struct {
      logic [3:0]  dest;
      logic [31:0] res;
   } ent_t;

   vec_t tbl[$];
   ent_t q[$];

   function automatic vec_t mk(logic v, logic [3:0] d, logic [31:0] r, logic rr, logic fl,
                               logic [3:0] s1, logic [3:0] s2, logic e_en, logic [3:0] e_dest,
                               logic [31:0] e_res, logic e_rdy, int e_cnt, logic e_h1,
                               logic [31:0] e_v1, logic e_h2, logic [31:0] e_v2);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.rr = rr; t.fl = fl; t.s1 = s1; t.s2 = s2;
      t.e_en = e_en; t.e_dest = e_dest; t.e_res = e_res; t.e_rdy = e_rdy; t.e_cnt = e_cnt;
      t.e_h1 = e_h1; t.e_v1 = e_v1; t.e_h2 = e_h2; t.e_v2 = e_v2;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic [31:0] r,
                        input logic rr, input logic fl, input logic [3:0] a,
                        input logic [3:0] b);
      in_valid  = v;
      in_dest   = d;
      in_result = r;
      rf_ready  = rr;
      flush     = fl;
      src1      = a;
      src2      = b;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        e_en, e_rdy, e_h1, e_h2;
      logic [31:0] e_v1, e_v2;
      int          sz;

      rst = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("reset wb_en", 32'(wb_en), 32'd0);
      chk("reset empty", 32'(empty), 32'd1);
      chk("reset full", 32'(full), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset count", 32'(count), 32'd0);
      chk("reset fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("reset fwd2_hit", 32'(fwd2_hit), 32'd0);
      next_cycle();

      // v d r rr fl s1 s2 | en dest res rdy cnt h1 v1 h2 v2
      tbl.push_back(mk(1, 3, 32'hDEADBEEF, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 3, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h101, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 32'h102, 0, 0, 4, 1, 0, 0, 0, 1, 1, 0, 0, 1, 32'h101));
      tbl.push_back(mk(1, 3, 32'h103, 0, 0, 4, 1, 0, 0, 0, 1, 2, 0, 0, 1, 32'h101));
      tbl.push_back(mk(1, 4, 32'h104, 0, 0, 4, 1, 0, 0, 0, 1, 3, 0, 0, 1, 32'h101));
      tbl.push_back(mk(1, 5, 32'h105, 0, 0, 4, 1, 0, 0, 0, 0, 4, 1, 32'h104, 1, 32'h101));
      tbl.push_back(mk(1, 5, 32'h105, 1, 0, 4, 1, 1, 1, 32'h101, 1, 4, 1, 32'h104, 1, 32'h101));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 1, 2, 32'h102, 1, 4, 1, 32'h104, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 1, 3, 32'h103, 1, 3, 1, 32'h104, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 1, 4, 32'h104, 1, 2, 1, 32'h104, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 1, 5, 32'h105, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7, 32'h11, 0, 0, 7, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7, 32'h22, 0, 0, 7, 9, 0, 0, 0, 1, 1, 1, 32'h11, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 7, 9, 0, 0, 0, 1, 2, 1, 32'h22, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 7, 9, 1, 7, 32'h11, 1, 2, 1, 32'h22, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 7, 9, 1, 7, 32'h22, 1, 1, 1, 32'h22, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 7, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 32'hA5A5A5A5, 0, 0, 2, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 9, 0, 0, 0, 1, 1, 1, 32'hA5A5A5A5, 0, 0));
      tbl.push_back(mk(1, 10, 32'h10A, 0, 0, 2, 9, 0, 0, 0, 1, 1, 1, 32'hA5A5A5A5, 0, 0));
      tbl.push_back(mk(1, 11, 32'h10B, 0, 0, 2, 9, 0, 0, 0, 1, 2, 1, 32'hA5A5A5A5, 0, 0));
      tbl.push_back(mk(1, 12, 32'h10C, 1, 1, 2, 9, 0, 0, 0, 1, 3, 1, 32'hA5A5A5A5, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 2, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 12, 10, 0, 0, 0, 1, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rr, tbl[i].fl, tbl[i].s1, tbl[i].s2);
         #2;
         chk($sformatf("row%0d wb_en", i), 32'(wb_en), 32'(tbl[i].e_en));
         if (tbl[i].e_en) begin
            chk($sformatf("row%0d wb_dest", i), 32'(wb_dest), 32'(tbl[i].e_dest));
            chk($sformatf("row%0d wb_result", i), wb_result, tbl[i].e_res);
         end
         chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
         chk($sformatf("row%0d empty", i), 32'(empty), 32'(tbl[i].e_cnt == 0));
         chk($sformatf("row%0d full", i), 32'(full), 32'(tbl[i].e_cnt == DEPTH));
         chk($sformatf("row%0d fwd1_hit", i), 32'(fwd1_hit), 32'(tbl[i].e_h1));
         chk($sformatf("row%0d fwd1_val", i), fwd1_val, tbl[i].e_v1);
         chk($sformatf("row%0d fwd2_hit", i), 32'(fwd2_hit), 32'(tbl[i].e_h2));
         chk($sformatf("row%0d fwd2_val", i), fwd2_val, tbl[i].e_v2);
         next_cycle();
      end

      // Asynchronous reset while the head is being written.
      drive(1'b1, 4'd6, 32'h66, 1'b0, 1'b0, 4'd6, 4'd8);
      next_cycle();
      drive(1'b1, 4'd8, 32'h88, 1'b0, 1'b0, 4'd6, 4'd8);
      next_cycle();
      drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd6, 4'd8);
      #2;
      chk("pre-rst wb_en", 32'(wb_en), 32'd1);
      chk("pre-rst wb_dest", 32'(wb_dest), 32'd6);
      rst = 1'b1;
      #1;
      chk("async rst wb_en", 32'(wb_en), 32'd0);
      chk("async rst count", 32'(count), 32'd0);
      chk("async rst fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("async rst fwd2_hit", 32'(fwd2_hit), 32'd0);
      next_cycle();
      rst = 1'b0;
      drive(1'b1, 4'd9, 32'h99, 1'b1, 1'b0, 4'd9, 4'd6);
      #2;
      chk("post-rst push cycle wb_en", 32'(wb_en), 32'd0);
      next_cycle();
      drive(1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd9, 4'd6);
      #2;
      chk("post-rst wb_en", 32'(wb_en), 32'd1);
      chk("post-rst wb_dest", 32'(wb_dest), 32'd9);
      chk("post-rst wb_result", wb_result, 32'h99);
      chk("post-rst stale fwd2_hit", 32'(fwd2_hit), 32'd0);
      next_cycle();
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd9, 4'd6);
      #2;
      chk("post-rst drained count", 32'(count), 32'd0);
      next_cycle();

      // Randomized traffic against a queue model.
      q.delete();
      for (int c = 0; c < 1500; c++) begin
         logic        v, rr, fl;
         logic [3:0]  d, a, b;
         logic [31:0] r;
         v  = ($urandom_range(0, 9) < 7);
         rr = ($urandom_range(0, 1) == 1);
         fl = ($urandom_range(0, 39) == 0);
         d  = 4'($urandom_range(0, 7));
         r  = $urandom;
         a  = 4'($urandom_range(0, 7));
         b  = 4'($urandom_range(0, 7));
         drive(v, d, r, rr, fl, a, b);

         sz    = q.size();
         e_en  = (sz > 0) && rr && !fl;
         e_rdy = (sz < DEPTH) || e_en;
         e_h1  = 1'b0; e_v1 = 32'd0;
         e_h2  = 1'b0; e_v2 = 32'd0;
         for (int k = sz - 1; k >= 0; k--) begin
            if (!e_h1 && q[k].dest == a) begin e_h1 = 1'b1; e_v1 = q[k].res; end
            if (!e_h2 && q[k].dest == b) begin e_h2 = 1'b1; e_v2 = q[k].res; end
         end

         #2;
         chk($sformatf("rnd%0d wb_en", c), 32'(wb_en), 32'(e_en));
         if (e_en) begin
            chk($sformatf("rnd%0d wb_dest", c), 32'(wb_dest), 32'(q[0].dest));
            chk($sformatf("rnd%0d wb_result", c), wb_result, q[0].res);
         end
         if (!fl) chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(e_rdy));
         chk($sformatf("rnd%0d count", c), 32'(count), 32'(sz));
         chk($sformatf("rnd%0d full", c), 32'(full), 32'(sz == DEPTH));
         chk($sformatf("rnd%0d fwd1_hit", c), 32'(fwd1_hit), 32'(e_h1));
         chk($sformatf("rnd%0d fwd1_val", c), fwd1_val, e_v1);
         chk($sformatf("rnd%0d fwd2_hit", c), 32'(fwd2_hit), 32'(e_h2));
         chk($sformatf("rnd%0d fwd2_val", c), fwd2_val, e_v2);

         if (fl) begin
            q.delete();
         end else begin
            ent_t e;
            if (e_en) void'(q.pop_front());
            if (v && e_rdy) begin
               e.dest = d;
               e.res  = r;
               q.push_back(e);
            end
         end
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_buffer.md
Name: wb_write_buffer

Overview:
- Writer side of the 16x32 register-file write port (wb_en / wb_dest / wb_result).
- Accepts writeback requests from the MEM/WB boundary over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires one request per cycle into the register file whenever the port is granted (rf_ready).
- Exposes a two-source forwarding lookup so decode sees results that are still buffered and not yet written.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- WORD_WIDTH, 32, result width; taken from the shared constants.
- REG_ADDR_W, 4, register index width; equals REG_FILE_DEPTH in the shared constants.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  writeback request present.
- in_ready  out  1  buffer can accept the request this cycle.
- in_dest  in  REG_ADDR_W  destination register.
- in_result  in  WORD_WIDTH  value to write.
- rf_ready  in  1  register-file write port granted this cycle.
- wb_en  out  1  write strobe to the register file.
- wb_dest  out  REG_ADDR_W  write address.
- wb_result  out  WORD_WIDTH  write data.
- src1  in  REG_ADDR_W  forwarding lookup address 1.
- src2  in  REG_ADDR_W  forwarding lookup address 2.
- fwd1_hit  out  1  src1 matches a buffered entry.
- fwd1_val  out  WORD_WIDTH  value for src1.
- fwd2_hit  out  1  src2 matches a buffered entry.
- fwd2_val  out  WORD_WIDTH  value for src2.
- count  out  log2(DEPTH)+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset: rst, asynchronous, active-high.
  - Clears rd_ptr, wr_ptr and count to 0.
  - wb_en=0, fwd1_hit=fwd2_hit=0, empty=1, full=0, in_ready=1.
  - Storage contents are not reset.
  - Reset mid-operation discards every pending entry, and wb_en drops immediately.
- Storage: circular array of DEPTH {dest, result} entries with per-slot valid bits; pointers wrap modulo DEPTH.
- Pop:
  - pop = !empty && rf_ready.
  - wb_en = pop; wb_dest / wb_result = head entry, driven combinationally from storage.
  - The register file captures on the negedge inside the same cycle, so the head must stay stable from posedge to posedge.
  - rd_ptr advances on the posedge following pop.
- Push:
  - in_ready = (count < DEPTH) || pop. A full buffer accepts a new entry in the same cycle it retires one.
  - push = in_valid && in_ready; the entry is written at wr_ptr on posedge.
- Latency: an accepted entry reaches the head no earlier than the next cycle. There is no same-cycle bypass from the input to wb_*.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Ordering: strict FIFO. Two entries with the same dest retire oldest first, so the last write wins in the register file.
- Forwarding:
  - For each srcN, search all valid entries; hit if any valid dest == srcN.
  - When several entries match, the youngest (nearest wr_ptr) supplies fwdN_val.
  - The request currently on the input is not searched.
  - An entry being popped this cycle still counts as a hit; its value is identical to what the register file receives.
  - On a miss, fwdN_val = 0.
- Flush:
  - Clears pointers, count and valid bits on the next posedge.
  - A push in the flush cycle is dropped.
  - wb_en is forced 0 during the flush cycle.
  - If flush and rst are both asserted, rst dominates.
- Register 15 gets no special treatment; PC writes are buffered like any other destination.

Decomposition:
- Shared constants header: WORD_WIDTH, REG_FILE_DEPTH, REG_FILE_SIZE.
- Natural sub-module: wb_fwd_match.
  - Parameterised priority search over DEPTH entries returning {hit, val} for one src.
  - Instantiated twice, once for src1 and once for src2.
  - Youngest-first order is derived from wr_ptr.

Test Plan:
- Reset, then push {dest=3, result=0xDEADBEEF} with rf_ready=1 → next cycle wb_en=1, wb_dest=3, wb_result=0xDEADBEEF; following cycle empty=1.
- Hold rf_ready=0 and push 4 entries (dests 1,2,3,4) → full=1, in_ready=0. Raise rf_ready with in_valid asserted for dest=5 → push accepted that cycle; retire order is 1,2,3,4,5.
- Push dest=7 with 0x11, then dest=7 with 0x22, holding rf_ready=0; src1=7 → fwd1_hit=1, fwd1_val=0x22. Release rf_ready → after the first pop, fwd1_val is still 0x22; after the second pop, fwd1_hit=0.
- src1=2, src2=9 with only dest=2 (0xA5A5A5A5) buffered → fwd1_hit=1, fwd1_val=0xA5A5A5A5; fwd2_hit=0, fwd2_val=0.
- Fill 3 entries, then assert flush together with in_valid → next cycle count=0, and wb_en is never asserted for the flushed or dropped entries.
- Assert rst asynchronously mid-cycle while wb_en=1 → wb_en falls immediately, count=0; first push after release appears at wb_* one cycle later.
